// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: range-checks RV32I field requests and packs them into instruction words.
// It emits each word with a sequential byte address through one valid/ready register stage.
module rv32i_inst_encoder #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq_Valid,
  output logic              oReq_Ready,
  input  logic [2:0]        iFmt,
  input  logic [2:0]        iFunct3,
  input  logic              iFunct7_5,
  input  logic [4:0]        iRd,
  input  logic [4:0]        iRs1,
  input  logic [4:0]        iRs2,
  input  logic [31:0]       iImm,
  output logic              oInst_Valid,
  input  logic              iInst_Ready,
  output logic [31:0]       oInst_Code,
  output logic [ADDR_W-1:0] oInst_Addr,
  output logic              oErr,
  output logic [1:0]        oErr_Code,
  output logic [15:0]       oCount
);
  logic              r_valid;
  logic [31:0]       r_code;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic [15:0]       r_count;
  logic              w_acc;
  logic              w_hs;
  logic              w_shift;
  logic              w_bad12;
  logic              w_badb;
  logic [1:0]        w_err;
  logic [6:0]        w_op;
  logic [31:0]       w_word;
  assign oReq_Ready  = ~r_valid | iInst_Ready;
  assign w_acc       = iReq_Valid & oReq_Ready;
  assign w_hs        = r_valid & iInst_Ready;
  assign oInst_Valid = r_valid;
  assign oInst_Code  = r_code;
  assign oInst_Addr  = r_addr;
  assign oErr        = r_err;
  assign oErr_Code   = r_err_code;
  assign oCount      = r_count;
  always_comb begin
    w_shift = (iFmt == 3'd1) && (iFunct3[1:0] == 2'b01);
    w_bad12 = ($signed(iImm) < -32'sd2048) || ($signed(iImm) > 32'sd2047);
    w_badb  = ($signed(iImm) < -32'sd4096) || ($signed(iImm) > 32'sd4094);
    w_err   = (iFmt == 3'd7) ? 2'd3 :
              ((iFmt == 3'd1 || iFmt == 3'd2 || iFmt == 3'd3) && w_bad12) ? 2'd1 :
              (w_shift && iImm > 32'd31) ? 2'd1 :
              (iFmt == 3'd4 && w_badb) ? 2'd1 :
              (iFmt == 3'd4 && iImm[0]) ? 2'd2 :
              ((iFmt == 3'd5 || iFmt == 3'd6) && iImm[11:0] != 12'd0) ? 2'd2 : 2'd0;
    w_op    = (iFmt == 3'd0) ? 7'b0110011 :
              (iFmt == 3'd1) ? 7'b0010011 :
              (iFmt == 3'd2) ? 7'b0000011 :
              (iFmt == 3'd3) ? 7'b0100011 :
              (iFmt == 3'd4) ? 7'b1100011 :
              (iFmt == 3'd5) ? 7'b0110111 : 7'b0010111;
    w_word  = (iFmt == 3'd0) ? {1'b0, iFunct7_5, 5'd0, iRs2, iRs1, iFunct3, iRd, w_op} :
              w_shift ? {1'b0, iFunct7_5, 5'd0, iImm[4:0], iRs1, iFunct3, iRd, w_op} :
              (iFmt == 3'd1 || iFmt == 3'd2) ? {iImm[11:0], iRs1, iFunct3, iRd, w_op} :
              (iFmt == 3'd3) ? {iImm[11:5], iRs2, iRs1, iFunct3, iImm[4:0], w_op} :
              (iFmt == 3'd4) ? {iImm[12], iImm[10:5], iRs2, iRs1, iFunct3, iImm[4:1], iImm[11], w_op} :
              {iImm[31:12], iRd, w_op};
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_addr     <= BASE_ADDR;
      r_err      <= 1'b0;
      r_err_code <= '0;
      r_count    <= '0;
    end else begin
      r_err <= w_acc && (w_err != 2'd0);
      if (w_acc && w_err != 2'd0) r_err_code <= w_err;
      if (w_hs) begin
        r_addr  <= r_addr + ADDR_W'(4);
        r_count <= r_count + 16'd1;
      end
      // a legal accept in the drain cycle reloads the stage instead of emptying it
      if (w_acc && w_err == 2'd0) begin
        r_valid <= 1'b1;
        r_code  <= w_word;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// tb_rv32i_inst_encoder: directed vectors with a queue-based scoreboard for the encoder.
// A second small-address instance exercises address wrap and mid-transfer reset.
module tb_rv32i_inst_encoder;
  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReq_Valid;
  logic        oReq_Ready;
  logic [2:0]  iFmt;
  logic [2:0]  iFunct3;
  logic        iFunct7_5;
  logic [4:0]  iRd;
  logic [4:0]  iRs1;
  logic [4:0]  iRs2;
  logic [31:0] iImm;
  logic        oInst_Valid;
  logic        iInst_Ready;
  logic [31:0] oInst_Code;
  logic [31:0] oInst_Addr;
  logic        oErr;
  logic [1:0]  oErr_Code;
  logic [15:0] oCount;
  logic        b_rst;
  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_inst_valid;
  logic        b_inst_ready;
  logic [31:0] b_code;
  logic [3:0]  b_addr;
  logic        b_err;
  logic [1:0]  b_err_code;
  logic [15:0] b_count;
  int total = 0;
  int bad = 0;
  int stalls = 0;
  int hs_n = 0;
  logic [31:0] exp_addr = 32'd0;
  logic [1:0]  exp_last_err = 2'd0;
  logic [63:0] word_q[$];
  logic [1:0]  err_q[$];
  always #5 iClk = ~iClk;
  rv32i_inst_encoder dut (
    .iClk(iClk), .iRst(iRst), .iReq_Valid(iReq_Valid), .oReq_Ready(oReq_Ready),
    .iFmt(iFmt), .iFunct3(iFunct3), .iFunct7_5(iFunct7_5), .iRd(iRd), .iRs1(iRs1),
    .iRs2(iRs2), .iImm(iImm), .oInst_Valid(oInst_Valid), .iInst_Ready(iInst_Ready),
    .oInst_Code(oInst_Code), .oInst_Addr(oInst_Addr), .oErr(oErr), .oErr_Code(oErr_Code),
    .oCount(oCount)
  );
  rv32i_inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_b (
    .iClk(iClk), .iRst(b_rst), .iReq_Valid(b_req_valid), .oReq_Ready(b_req_ready),
    .iFmt(iFmt), .iFunct3(iFunct3), .iFunct7_5(iFunct7_5), .iRd(iRd), .iRs1(iRs1),
    .iRs2(iRs2), .iImm(iImm), .oInst_Valid(b_inst_valid), .iInst_Ready(b_inst_ready),
    .oInst_Code(b_code), .oInst_Addr(b_addr), .oErr(b_err), .oErr_Code(b_err_code),
    .oCount(b_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  // monitor: inputs only change just after posedge, so negedge sees the coming handshake
  always @(negedge iClk) begin
    if (!iRst) begin
      if (oInst_Valid && iInst_Ready) begin
        if (word_q.size() == 0) chk("spurious_word", oInst_Code, 32'hFFFF_FFFF);
        else begin
          logic [63:0] e;
          e = word_q.pop_front();
          chk("word_code", oInst_Code, e[63:32]);
          chk("word_addr", oInst_Addr, e[31:0]);
          chk("word_count", {16'd0, oCount}, hs_n);
          hs_n++;
        end
      end
      if (oErr) begin
        if (err_q.size() == 0) chk("spurious_err", {30'd0, oErr_Code}, 32'hFFFF_FFFF);
        else chk("err_code", {30'd0, oErr_Code}, {30'd0, err_q.pop_front()});
      end
    end
  end
  task automatic send(input logic [2:0] fmt, input logic [2:0] f3, input logic f75,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic [31:0] exp_code, input logic [1:0] exp_err);
    int n;
    iFmt = fmt; iFunct3 = f3; iFunct7_5 = f75; iRd = rd; iRs1 = rs1; iRs2 = rs2; iImm = imm;
    iReq_Valid = 1'b1;
    n = 0;
    @(negedge iClk);
    while (!oReq_Ready && n < 50) begin
      n++;
      stalls++;
      @(negedge iClk);
    end
    if (!oReq_Ready) chk("req_timeout", 32'd0, 32'd1);
    if (exp_err == 2'd0) begin
      word_q.push_back({exp_code, exp_addr});
      exp_addr += 32'd4;
    end else begin
      err_q.push_back(exp_err);
      exp_last_err = exp_err;
    end
    @(posedge iClk);
    #1 iReq_Valid = 1'b0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while ((word_q.size() != 0 || err_q.size() != 0) && n < 100) begin
      n++;
      @(posedge iClk);
    end
    #1;
    if (word_q.size() != 0 || err_q.size() != 0) chk("drain_timeout", word_q.size(), 0);
  endtask
  initial begin
    logic [31:0] h_code;
    logic [31:0] h_addr;
    iRst = 1'b1; b_rst = 1'b1; iReq_Valid = 1'b0; b_req_valid = 1'b0;
    iInst_Ready = 1'b1; b_inst_ready = 1'b1;
    iFmt = 3'd0; iFunct3 = 3'd0; iFunct7_5 = 1'b0; iRd = 5'd0; iRs1 = 5'd0; iRs2 = 5'd0; iImm = 32'd0;
    repeat (2) @(posedge iClk);
    #1;
    chk("rst_valid", {31'd0, oInst_Valid}, 0);
    chk("rst_code", oInst_Code, 0);
    chk("rst_addr", oInst_Addr, 0);
    chk("rst_err", {31'd0, oErr}, 0);
    chk("rst_err_code", {30'd0, oErr_Code}, 0);
    chk("rst_count", {16'd0, oCount}, 0);
    chk("rst_b_addr", {28'd0, b_addr}, 32'hC);
    iRst = 1'b0; b_rst = 1'b0;
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 2'd0);
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 2'd0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 2'd0);
    send(3'd1, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093, 2'd0);
    send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 2'd0);
    send(3'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 2'd0);
    send(3'd2, 3'd2, 1'b0, 5'd2, 5'd1, 5'd0, -32'sd4, 32'hFFC0A103, 2'd0);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF00093, 2'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 32'hFE208CE3, 2'd0);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E000FE3, 2'd0);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000, 32'h00001097, 2'd0);
    drain();
    repeat (2) @(posedge iClk);
    #1;
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd7, 32'd0, 2'd2);
    chk("illegal_no_valid", {31'd0, oInst_Valid}, 0);
    chk("illegal_err_pulse", {31'd0, oErr}, 1);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'd0, 2'd1);
    send(3'd1, 3'd1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd32, 32'd0, 2'd1);
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096, 32'd0, 2'd1);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001001, 32'd0, 2'd2);
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 2'd3);
    drain();
    chk("err_addr_unchanged", oInst_Addr, exp_addr);
    chk("err_count_unchanged", {16'd0, oCount}, hs_n);
    iInst_Ready = 1'b0;
    send(3'd0, 3'd0, 1'b0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h00628233, 2'd0);
    h_code = oInst_Code;
    h_addr = oInst_Addr;
    chk("hold_code_loaded", h_code, 32'h00628233);
    repeat (3) begin
      @(negedge iClk);
      chk("hold_code", oInst_Code, h_code);
      chk("hold_addr", oInst_Addr, h_addr);
      chk("hold_ready_low", {31'd0, oReq_Ready}, 0);
    end
    @(posedge iClk);
    #1 iInst_Ready = 1'b1;
    stalls = 0;
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 2'd0);
    chk("release_addr", oInst_Addr, h_addr + 32'd4);
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 2'd0);
    send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3, 2'd0);
    chk("full_rate_stalls", stalls, 0);
    drain();
    repeat (2) @(posedge iClk);
    #1;
    chk("final_addr", oInst_Addr, exp_addr);
    chk("final_count", {16'd0, oCount}, hs_n);
    chk("final_err_code_held", {30'd0, oErr_Code}, {30'd0, exp_last_err});
    chk("final_idle", {31'd0, oInst_Valid}, 0);
    iFmt = 3'd1; iFunct3 = 3'd0; iRd = 5'd1; iRs1 = 5'd0; iImm = 32'd5;
    b_req_valid = 1'b1;
    @(posedge iClk);
    #1 b_req_valid = 1'b0;
    chk("b_first_addr", {28'd0, b_addr}, 32'hC);
    chk("b_first_code", b_code, 32'h00500093);
    @(posedge iClk);
    #1;
    chk("b_wrap_addr", {28'd0, b_addr}, 32'h0);
    chk("b_count", {16'd0, b_count}, 1);
    b_inst_ready = 1'b0;
    b_req_valid = 1'b1;
    @(posedge iClk);
    #1 b_req_valid = 1'b0;
    chk("b_held_valid", {31'd0, b_inst_valid}, 1);
    b_rst = 1'b1;
    @(posedge iClk);
    #1 b_rst = 1'b0;
    chk("b_rst_valid", {31'd0, b_inst_valid}, 0);
    chk("b_rst_addr", {28'd0, b_addr}, 32'hC);
    chk("b_rst_count", {16'd0, b_count}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
